// File: rtl/dm_golden_checker.sv
// Self-check engine: walks FIRST_IDX..LAST_IDX, compares DM words against a golden ROM and counts mismatches.
// Optional macro CHK_STOP_ON_FAIL_EN: stop issuing after the first mismatch and drain.
module dm_golden_checker #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned FIRST_IDX = 1,
  parameter int unsigned LAST_IDX  = 31,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned CNT_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              mis_valid,
  output logic [ADDR_W-1:0] mis_idx,
  output logic [DATA_W-1:0] mis_got,
  output logic [DATA_W-1:0] mis_exp
);

  localparam logic [ADDR_W-1:0] FIRST_A     = ADDR_W'(FIRST_IDX);
  localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(LAST_IDX);
  localparam bit                EMPTY_RANGE = (FIRST_IDX > LAST_IDX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_e;

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                mis_valid_q, mis_valid_d;
  logic [ADDR_W-1:0]   mis_idx_q, mis_idx_d;
  logic [DATA_W-1:0]   mis_got_q, mis_got_d;
  logic [DATA_W-1:0]   mis_exp_q, mis_exp_d;
  logic [RD_LAT-1:0]   pv_q, pv_d;
  logic [ADDR_W-1:0]   pidx_q [RD_LAT];
  logic [ADDR_W-1:0]   pidx_d [RD_LAT];

  logic mismatch_c;
  logic in_flight_c;
  logic stop_c;

  // Next-state, compare and output logic
  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    mis_valid_d = 1'b0;
    mis_idx_d   = mis_idx_q;
    mis_got_d   = mis_got_q;
    mis_exp_d   = mis_exp_q;

    pv_d[0]   = mem_en_q;
    pidx_d[0] = mem_addr_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pv_d[i]   = pv_q[i-1];
      pidx_d[i] = pidx_q[i-1];
    end

    // Entries still in flight other than the one exiting this cycle
    in_flight_c = mem_en_q;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
      in_flight_c = in_flight_c | pv_q[i];
    end

    mismatch_c = pv_q[RD_LAT-1] && (mem_rdata != gold_data);
`ifdef CHK_STOP_ON_FAIL_EN
    stop_c = mismatch_c;
`else
    stop_c = 1'b0;
`endif

    if (mismatch_c) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      mis_valid_d = 1'b1;
      mis_idx_d   = pidx_q[RD_LAT-1];
      mis_got_d   = mem_rdata;
      mis_exp_d   = gold_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_cnt_d = '0;
          pass_d    = 1'b0;
          if (EMPTY_RANGE) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_ISSUE;
            mem_en_d   = 1'b1;
            mem_addr_d = FIRST_A;
          end
        end
      end
      S_ISSUE: begin
        // Compare before increment so LAST_IDX at the top of the range never wraps
        if ((mem_addr_q == LAST_A) || stop_c) begin
          state_d = S_DRAIN;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (!in_flight_c) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_FIN);
    if (state_d == S_FIN) begin
      pass_d = (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      mis_valid_q <= 1'b0;
      mis_idx_q   <= '0;
      mis_got_q   <= '0;
      mis_exp_q   <= '0;
      pv_q        <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pidx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      mis_valid_q <= mis_valid_d;
      mis_idx_q   <= mis_idx_d;
      mis_got_q   <= mis_got_d;
      mis_exp_q   <= mis_exp_d;
      pv_q        <= pv_d;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pidx_q[i] <= pidx_d[i];
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign gold_addr = mem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign mis_valid = mis_valid_q;
  assign mis_idx   = mis_idx_q;
  assign mis_got   = mis_got_q;
  assign mis_exp   = mis_exp_q;

endmodule

// File: tb/tb_dm_golden_checker.sv
// Bench for dm_golden_checker: three configurations (defaults, RD_LAT=3/CNT_W=2, top-of-range 4-bit index).
module tb_dm_golden_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] start_v = 3'b000;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults
  logic        mem_en_a, busy_a, done_a, pass_a, mv_a;
  logic [15:0] mem_addr_a, gold_addr_a, mi_a;
  logic [31:0] rd_a, gd_a, mg_a, me_a;
  logic [11:0] err_a;
  // Instance B: RD_LAT=3, CNT_W=2
  logic        mem_en_b, busy_b, done_b, pass_b, mv_b;
  logic [15:0] mem_addr_b, gold_addr_b, mi_b;
  logic [31:0] rd_b, gd_b, mg_b, me_b, b1, b2, bg1, bg2;
  logic [1:0]  err_b;
  // Instance C: ADDR_W=4, range 12..15 ends at the top index
  logic        mem_en_c, busy_c, done_c, pass_c, mv_c;
  logic [3:0]  mem_addr_c, gold_addr_c, mi_c;
  logic [31:0] rd_c, gd_c, mg_c, me_c;
  logic [11:0] err_c;

  dm_golden_checker u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .mem_en(mem_en_a), .mem_addr(mem_addr_a),
    .mem_rdata(rd_a), .gold_addr(gold_addr_a), .gold_data(gd_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .mis_valid(mv_a), .mis_idx(mi_a), .mis_got(mg_a), .mis_exp(me_a));

  dm_golden_checker #(.RD_LAT(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
    .mem_rdata(rd_b), .gold_addr(gold_addr_b), .gold_data(gd_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .mis_valid(mv_b), .mis_idx(mi_b), .mis_got(mg_b), .mis_exp(me_b));

  dm_golden_checker #(.ADDR_W(4), .FIRST_IDX(12), .LAST_IDX(15)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .mem_en(mem_en_c), .mem_addr(mem_addr_c),
    .mem_rdata(rd_c), .gold_addr(gold_addr_c), .gold_data(gd_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_cnt(err_c), .mis_valid(mv_c), .mis_idx(mi_c), .mis_got(mg_c), .mis_exp(me_c));

  wire [2:0] busy_v = {busy_c, busy_b, busy_a};
  wire [2:0] done_v = {done_c, done_b, done_a};
  wire [2:0] pass_v = {pass_c, pass_b, pass_a};

  // Memory contents per instance; golden word at index i is i
  logic [31:0] mem [3][64];
  int first_i [3] = '{1, 1, 12};
  int last_i  [3] = '{31, 31, 15};
  int lat_i   [3] = '{1, 3, 1};
  int t0      [3] = '{0, 0, 0};
  int done_cnt[3] = '{0, 0, 0};
  int en_cnt  [3] = '{0, 0, 0};

  always @(posedge clk) begin
    rd_a <= mem[0][mem_addr_a[5:0]];
    gd_a <= 32'(mem_addr_a);
    b1   <= mem[1][mem_addr_b[5:0]];
    bg1  <= 32'(mem_addr_b);
    b2   <= b1;
    bg2  <= bg1;
    rd_b <= b2;
    gd_b <= bg2;
    rd_c <= mem[2][{2'b00, mem_addr_c}];
    gd_c <= 32'(mem_addr_c);
  end

  typedef struct {
    int          k;
    int          idx;
    logic [31:0] got;
    logic [31:0] exp;
    int          cyc;
  } mis_t;
  mis_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int err_of(input int k);
    if (k == 0) return int'(err_a);
    if (k == 1) return int'(err_b);
    return int'(err_c);
  endfunction

  // Per-cycle monitor: issue addresses and mismatch reports against the scoreboard
  task automatic mon(input int k, input logic mv, input int mi, input logic [31:0] mg,
                     input logic [31:0] me, input logic en, input int ma, input int ga, input logic dn);
    mis_t e;
    if (dn) done_cnt[k]++;
    if (en) begin
      en_cnt[k]++;
      chk($sformatf("mem_addr%0d", k), ma, first_i[k] + cyc - t0[k] - 1);
      chk($sformatf("gold_addr%0d", k), ga, ma);
    end
    if (mv) begin
      chk($sformatf("mis_expected%0d", k), int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("mis_inst", k, e.k);
        chk("mis_idx", mi, e.idx);
        chk("mis_got", mg, e.got);
        chk("mis_exp", me, e.exp);
        chk("mis_cyc", cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, mv_a, int'(mi_a), mg_a, me_a, mem_en_a, int'(mem_addr_a), int'(gold_addr_a), done_a);
      mon(1, mv_b, int'(mi_b), mg_b, me_b, mem_en_b, int'(mem_addr_b), int'(gold_addr_b), done_b);
      mon(2, mv_c, int'(mi_c), mg_c, me_c, mem_en_c, int'(mem_addr_c), int'(gold_addr_c), done_c);
    end
  end

  task automatic push_expected(input int k, input int lo, input int hi);
    mis_t e;
    for (int i = lo; i <= hi; i++) begin
      if (mem[k][i] !== 32'(i)) begin
        e.k   = k;
        e.idx = i;
        e.got = mem[k][i];
        e.exp = 32'(i);
        e.cyc = t0[k] + (i - first_i[k] + 1) + lat_i[k] + 1;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic do_run(input int k, input int exp_err, input string tag);
    int n;
    int got_cyc;
    n = last_i[k] - first_i[k] + 1;
    got_cyc = -1;
    @(posedge clk); #1;
    t0[k] = cyc;
    done_cnt[k] = 0;
    en_cnt[k] = 0;
    push_expected(k, first_i[k], last_i[k]);
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    chk({tag, "_busy"}, busy_v[k], 1);
    for (int c = 0; c < 200 && got_cyc < 0; c++) begin
      @(negedge clk);
      if (done_v[k]) got_cyc = cyc;
    end
    chk({tag, "_done_cyc"}, got_cyc, t0[k] + n + lat_i[k] + 1);
    chk({tag, "_pass"}, pass_v[k], (exp_err == 0) ? 1 : 0);
    chk({tag, "_err_cnt"}, err_of(k), exp_err);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done_v[k], 0);
    chk({tag, "_busy_end"}, busy_v[k], 0);
    chk({tag, "_done_cnt"}, done_cnt[k], 1);
    chk({tag, "_issue_cnt"}, en_cnt[k], n);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    chk({tag, "_pass_hold"}, pass_v[k], (exp_err == 0) ? 1 : 0);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_mem_en"}, mem_en_a, 0);
    chk({tag, "_mem_addr"}, mem_addr_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_err_cnt"}, err_a, 0);
    chk({tag, "_mis_valid"}, mv_a, 0);
    chk({tag, "_mis_idx"}, mi_a, 0);
    chk({tag, "_mis_got"}, mg_a, 0);
    chk({tag, "_mis_exp"}, me_a, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) mem[k][i] = 32'(i);

    repeat (2) @(negedge clk);
    chk_zero_a("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    do_run(0, 0, "a_match");

    mem[0][5]  = 32'hDEAD_BEEF;
    mem[0][31] = 32'h1234_5678;
    do_run(0, 2, "a_mis2");

    // Mid-run restart attempt, then asynchronous reset
    mem[0][31] = 32'd31;
    @(posedge clk); #1;
    t0[0] = cyc;
    done_cnt[0] = 0;
    push_expected(0, 5, 5);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("restart_busy", busy_a, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_err_cnt", err_a, 1);
    chk("pre_reset_mis_idx", mi_a, 5);
    rst = 1'b0;
    #1;
    chk_zero_a("midrun_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("aborted_no_done", done_cnt[0], 0);
    chk("aborted_sb_empty", sbq.size(), 0);
    chk("aborted_err_cnt", err_a, 0);

    mem[0][5] = 32'd5;
    do_run(0, 0, "a_fresh");

    do_run(1, 0, "b_match");
    for (int i = 1; i <= 31; i++) mem[1][i] = ~32'(i);
    do_run(1, 3, "b_sat");

    mem[2][15] = 32'hFFFF_0000;
    do_run(2, 1, "c_top");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
